// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: datapath width, x0 index, ALU opcodes and
// the packed per-instruction control word carried down the pipeline.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam logic [4:0]  REG_X0 = 5'd0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    // Bit order matches the 8-bit control buses: {alu_op, alusrc, memread, memwrite, regwrite}
    typedef struct packed {
        alu_op_e alu_op;
        logic    alusrc;
        logic    memread;
        logic    memwrite;
        logic    regwrite;
    } ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// Single-operand forwarding select: x0, then EX, MEM, WB, then register file.
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic [4:0]      rs_i,
    input  logic [XLEN-1:0] rf_data_i,
    input  logic            ex_en_i,
    input  logic [4:0]      ex_rd_i,
    input  logic [XLEN-1:0] ex_data_i,
    input  logic            mem_en_i,
    input  logic [4:0]      mem_rd_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] operand_o
);

    // Youngest producer wins; x0 is hard zero regardless of any writer.
    always_comb begin
        operand_o = rf_data_i;
        if (rs_i == REG_X0) begin
            operand_o = '0;
        end else if (ex_en_i && (ex_rd_i == rs_i)) begin
            operand_o = ex_data_i;
        end else if (mem_en_i && (mem_rd_i == rs_i)) begin
            operand_o = mem_data_i;
        end else if (wb_en_i && (wb_rd_i == rs_i)) begin
            operand_o = wb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble
// insertion, flush and downstream hold.
module id_ex_stage #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [7:0]      id_ctrl,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [4:0]      mem_rd,
    input  logic            mem_regwrite,
    input  logic [XLEN-1:0] mem_data,
    input  logic [4:0]      wb_rd,
    input  logic            wb_regwrite,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            hold,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [7:0]      ex_ctrl
);
    import riscv_pkg::*;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rd_q, rd_d;
    ctrl_t           ctrl_q, ctrl_d;

    logic            ex_fwd_en;
    logic            luse;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;

    // A load in EX has no result yet, so it must not be forwarded from EX.
    assign ex_fwd_en = valid_q && ctrl_q.regwrite && !ctrl_q.memread;

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_i       (id_rs1),
        .rf_data_i  (rf_rs1_data),
        .ex_en_i    (ex_fwd_en),
        .ex_rd_i    (rd_q),
        .ex_data_i  (ex_alu_result),
        .mem_en_i   (mem_regwrite),
        .mem_rd_i   (mem_rd),
        .mem_data_i (mem_data),
        .wb_en_i    (wb_regwrite),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data),
        .operand_o  (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_i       (id_rs2),
        .rf_data_i  (rf_rs2_data),
        .ex_en_i    (ex_fwd_en),
        .ex_rd_i    (rd_q),
        .ex_data_i  (ex_alu_result),
        .mem_en_i   (mem_regwrite),
        .mem_rd_i   (mem_rd),
        .mem_data_i (mem_data),
        .wb_en_i    (wb_regwrite),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data),
        .operand_o  (rs2_fwd)
    );

    // Load-use detection and upstream stall; built only from inputs and
    // registered state so stall never feeds back on itself.
    always_comb begin
        luse  = id_valid && valid_q && ctrl_q.memread && (rd_q != REG_X0) &&
                ((id_use_rs1 && (id_rs1 == rd_q)) || (id_use_rs2 && (id_rs2 == rd_q)));
        stall = !reset && !flush && (hold || luse);
    end

    // Next ID/EX contents: flush, then hold, then bubble, then capture.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
            pc_d    = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            imm_d   = '0;
            rd_d    = '0;
            ctrl_d  = '0;
        end else if (hold) begin
            valid_d = valid_q;
        end else if (luse) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else begin
            valid_d = id_valid;
            pc_d    = id_pc;
            rs1_d   = rs1_fwd;
            rs2_d   = rs2_fwd;
            imm_d   = id_imm;
            rd_d    = id_rd;
            ctrl_d  = id_valid ? ctrl_t'(id_ctrl) : '0;
        end
    end

    // ID/EX register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_pc      = pc_q;
    assign ex_rs1_val = rs1_q;
    assign ex_rs2_val = rs2_q;
    assign ex_imm     = imm_q;
    assign ex_rd      = rd_q;
    assign ex_ctrl    = ctrl_q;

endmodule
